// File: rtl/sump_cmd_decoder_if.sv
// Byte-stream input and decoded-command output bundle of the SUMP command decoder.
// The decoder takes the slave modport; the UART/controller side takes master.
interface sump_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        cmd_recv_rx;
  logic        cmd_long;
  logic        timeout_err;

  modport master (
    output rx_data, rx_valid,
    input  opcode, command, cmd_recv_rx, cmd_long, timeout_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output opcode, command, cmd_recv_rx, cmd_long, timeout_err
  );
endinterface

// File: rtl/sump_cmd_decoder.sv
// SUMP command assembler: short (1-byte) and long (opcode + 4 data bytes) commands,
// with an inter-byte timeout that drops partial long commands.
module sump_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic              clock,
  input logic              ext_reset_n,
  sump_cmd_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        pend_op_q, pend_op_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [31:0]       command_q, command_d;
  logic              long_q, long_d;
  logic              strobe_q, strobe_d;
  logic              tout_q, tout_d;

  always_ff @(posedge clock or negedge ext_reset_n) begin
    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!ext_reset_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      shift_q    <= '0;
      pend_op_q  <= '0;
      opcode_q   <= '0;
      command_q  <= '0;
      long_q     <= 1'b0;
      strobe_q   <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      shift_q    <= shift_d;
      pend_op_q  <= pend_op_d;
      opcode_q   <= opcode_d;
      command_q  <= command_d;
      long_q     <= long_d;
      strobe_q   <= strobe_d;
      tout_q     <= tout_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    shift_d    = shift_q;
    pend_op_d  = pend_op_q;
    opcode_d   = opcode_q;
    command_d  = command_q;
    long_d     = long_q;
    strobe_d   = 1'b0;
    tout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (bus.rx_valid) begin
          if (!bus.rx_data[7]) begin
            opcode_d  = bus.rx_data;
            command_d = '0;
            long_d    = 1'b0;
            strobe_d  = 1'b1;
          end else begin
            // Published opcode stays put until the long command actually completes.
            pend_op_d  = bus.rx_data;
            byte_cnt_d = '0;
            shift_d    = '0;
            state_d    = COLLECT;
          end
        end
      end

      COLLECT: begin
        if (bus.rx_valid) begin
          // A byte on the terminal cycle wins over the timeout.
          tmo_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            opcode_d   = pend_op_q;
            command_d  = {bus.rx_data, shift_q[31:8]};
            long_d     = 1'b1;
            strobe_d   = 1'b1;
            byte_cnt_d = '0;
            shift_d    = '0;
            pend_op_d  = '0;
            state_d    = IDLE;
          end else begin
            shift_d    = {bus.rx_data, shift_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (tmo_cnt_q == CNT_TERM) begin
          tout_d     = 1'b1;
          tmo_cnt_d  = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          pend_op_d  = '0;
          state_d    = IDLE;
        end else if (tmo_cnt_q != CNT_MAX) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.opcode      = opcode_q;
  assign bus.command     = command_q;
  assign bus.cmd_long    = long_q;
  assign bus.cmd_recv_rx = strobe_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Self-checking bench for sump_cmd_decoder: directed scenarios plus randomized
// traffic compared cycle by cycle against a byte-queue reference model.
module tb_sump_cmd_decoder;

  localparam int unsigned TMO = 16;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  sump_cmd_decoder_if bus_if ();

  sump_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock       (clk),
    .ext_reset_n (rst_n),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes of the partial long command waiting in a queue,
  // plus the number of idle cycles since the last accepted byte.
  logic [7:0]  pend_q[$];
  int          idle_cycles;
  logic [7:0]  exp_opcode;
  logic [31:0] exp_command;
  logic        exp_long;
  logic        exp_strobe;
  logic        exp_tout;

  task automatic model_reset();
    pend_q.delete();
    idle_cycles = 0;
    exp_opcode  = 8'h00;
    exp_command = 32'h0;
    exp_long    = 1'b0;
    exp_strobe  = 1'b0;
    exp_tout    = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    exp_strobe = 1'b0;
    exp_tout   = 1'b0;
    if (v) begin
      if (pend_q.size() == 0 && !d[7]) begin
        exp_opcode  = d;
        exp_command = 32'h0;
        exp_long    = 1'b0;
        exp_strobe  = 1'b1;
      end else begin
        pend_q.push_back(d);
        idle_cycles = 0;
        if (pend_q.size() == 5) begin
          exp_opcode  = pend_q[0];
          exp_command = pend_q[1] + (pend_q[2] * 32'd256) + (pend_q[3] * 32'd65536)
                        + (pend_q[4] * 32'd16777216);
          exp_long    = 1'b1;
          exp_strobe  = 1'b1;
          pend_q.delete();
        end
      end
    end else if (pend_q.size() != 0) begin
      idle_cycles++;
      if (idle_cycles == TMO) begin
        pend_q.delete();
        idle_cycles = 0;
        exp_tout    = 1'b1;
      end
    end
  endtask

  // Drive one cycle of input, advance past the edge, compare every output to the model.
  task automatic drive_cycle(input logic v, input logic [7:0] d);
    bus_if.rx_valid = v;
    bus_if.rx_data  = d;
    model_step(v, d);
    @(posedge clk);
    #1;
    total++;
    if ({bus_if.opcode, bus_if.command, bus_if.cmd_long, bus_if.cmd_recv_rx, bus_if.timeout_err}
        !== {exp_opcode, exp_command, exp_long, exp_strobe, exp_tout}) begin
      bad++;
      $display("FAIL model_cycle t=%0t: got op=%h cmd=%h long=%b stb=%b tout=%b, want op=%h cmd=%h long=%b stb=%b tout=%b",
               $time, bus_if.opcode, bus_if.command, bus_if.cmd_long, bus_if.cmd_recv_rx,
               bus_if.timeout_err, exp_opcode, exp_command, exp_long, exp_strobe, exp_tout);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus_if.opcode, bus_if.command, bus_if.cmd_long, bus_if.cmd_recv_rx, bus_if.timeout_err} !== 43'h0) begin
      bad++;
      $display("FAIL reset_state: got op=%h cmd=%h long=%b stb=%b tout=%b, want all zero",
               bus_if.opcode, bus_if.command, bus_if.cmd_long, bus_if.cmd_recv_rx, bus_if.timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_short();
    drive_cycle(1'b1, 8'h02);
    total++;
    if ({bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long} !== {1'b1, 8'h02, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL short_cmd: got stb=%b op=%h cmd=%h long=%b, want stb=1 op=02 cmd=0 long=0",
               bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long);
    end
    drive_cycle(1'b0, 8'h00);
    total++;
    if (bus_if.cmd_recv_rx !== 1'b0) begin
      bad++;
      $display("FAIL short_pulse_width: got stb=%b, want 0", bus_if.cmd_recv_rx);
    end
  endtask

  task automatic test_long();
    logic [7:0] seq [5] = '{8'h80, 8'h10, 8'h32, 8'h54, 8'h76};
    int early = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, seq[i]);
      if (i < 4) begin
        if (bus_if.cmd_recv_rx) early++;
        idle(2);
      end
    end
    total++;
    if ({early[7:0], bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long}
        !== {8'd0, 1'b1, 8'h80, 32'h76543210, 1'b1}) begin
      bad++;
      $display("FAIL long_cmd: got early=%0d stb=%b op=%h cmd=%h long=%b, want early=0 stb=1 op=80 cmd=76543210 long=1",
               early, bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [6] = '{8'hC0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, seq[i]);
    total++;
    if ({bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long} !== {1'b1, 8'hC0, 32'h1, 1'b1}) begin
      bad++;
      $display("FAIL b2b_first: got stb=%b op=%h cmd=%h long=%b, want stb=1 op=c0 cmd=00000001 long=1",
               bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long);
    end
    drive_cycle(1'b1, seq[5]);
    total++;
    if ({bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long} !== {1'b1, 8'h04, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second: got stb=%b op=%h cmd=%h long=%b, want stb=1 op=04 cmd=0 long=0",
               bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command, bus_if.cmd_long);
    end
    idle(1);
  endtask

  task automatic test_timeout();
    logic [7:0] prior_op;
    int pulses = 0;
    int pulse_at = -1;
    int touts = 0;
    prior_op = bus_if.opcode;
    drive_cycle(1'b1, 8'h81);
    drive_cycle(1'b1, 8'hAA);
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b0, 8'h00);
      if (bus_if.timeout_err) begin
        pulses++;
        pulse_at = i;
      end
    end
    total++;
    if (pulses != 1 || pulse_at != TMO || bus_if.opcode !== prior_op) begin
      bad++;
      $display("FAIL timeout_pulse: got pulses=%0d at=%0d op=%h, want pulses=1 at=%0d op=%h",
               pulses, pulse_at, bus_if.opcode, TMO, prior_op);
    end
    drive_cycle(1'b1, 8'h02);
    total++;
    if ({bus_if.cmd_recv_rx, bus_if.opcode, bus_if.cmd_long} !== {1'b1, 8'h02, 1'b0}) begin
      bad++;
      $display("FAIL timeout_recover: got stb=%b op=%h long=%b, want stb=1 op=02 long=0",
               bus_if.cmd_recv_rx, bus_if.opcode, bus_if.cmd_long);
    end
    // Byte landing exactly on the terminal idle cycle must be accepted.
    drive_cycle(1'b1, 8'h85);
    drive_cycle(1'b1, 8'h01);
    for (int i = 0; i < TMO - 1; i++) begin
      drive_cycle(1'b0, 8'h00);
      if (bus_if.timeout_err) touts++;
    end
    drive_cycle(1'b1, 8'h02);
    if (bus_if.timeout_err) touts++;
    drive_cycle(1'b1, 8'h03);
    drive_cycle(1'b1, 8'h04);
    total++;
    if ({touts[7:0], bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command} !== {8'd0, 1'b1, 8'h85, 32'h04030201}) begin
      bad++;
      $display("FAIL timeout_terminal_byte: got touts=%0d stb=%b op=%h cmd=%h, want touts=0 stb=1 op=85 cmd=04030201",
               touts, bus_if.cmd_recv_rx, bus_if.opcode, bus_if.command);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 8'h82);
    drive_cycle(1'b1, 8'h11);
    drive_cycle(1'b1, 8'h22);
    bus_if.rx_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus_if.opcode, bus_if.command, bus_if.cmd_long, bus_if.cmd_recv_rx, bus_if.timeout_err} !== 43'h0) begin
      bad++;
      $display("FAIL async_reset: got op=%h cmd=%h long=%b stb=%b tout=%b, want all zero",
               bus_if.opcode, bus_if.command, bus_if.cmd_long, bus_if.cmd_recv_rx, bus_if.timeout_err);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 8'h33);
    total++;
    if ({bus_if.cmd_recv_rx, bus_if.opcode, bus_if.cmd_long} !== {1'b1, 8'h33, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_first: got stb=%b op=%h long=%b, want stb=1 op=33 long=0",
               bus_if.cmd_recv_rx, bus_if.opcode, bus_if.cmd_long);
    end
    drive_cycle(1'b1, 8'h44);
    total++;
    if ({bus_if.cmd_recv_rx, bus_if.opcode, bus_if.cmd_long} !== {1'b1, 8'h44, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid_second: got stb=%b op=%h long=%b, want stb=1 op=44 long=0",
               bus_if.cmd_recv_rx, bus_if.opcode, bus_if.cmd_long);
    end
    idle(1);
  endtask

  task automatic test_sump_reset();
    int strobes = 0;
    int touts = 0;
    drive_cycle(1'b1, 8'h55);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 8'h00);
      if (bus_if.cmd_recv_rx && bus_if.opcode === 8'h00 && bus_if.command === 32'h0) strobes++;
      if (bus_if.timeout_err) touts++;
    end
    for (int i = 0; i < TMO + 4; i++) begin
      drive_cycle(1'b0, 8'h00);
      if (bus_if.timeout_err) touts++;
    end
    total++;
    if (strobes != 5 || touts != 0) begin
      bad++;
      $display("FAIL sump_reset: got strobes=%0d touts=%0d, want strobes=5 touts=0", strobes, touts);
    end
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 40) == 0) begin
        gap = $urandom_range(TMO - 2, TMO + 2);
        idle(gap);
      end else begin
        drive_cycle(1'($urandom_range(0, 2) != 0), 8'($urandom));
      end
    end
    idle(TMO + 2);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_sump_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
- Assembles SUMP-protocol commands from the UART receiver byte stream and hands them to the controller as `opcode` plus a 32-bit `command`, with a one-cycle `cmd_recv_rx` strobe.
- Sits directly upstream of the controller, between the UART receiver and the controller.
- Opcode MSB=0: short (1-byte) command. Opcode MSB=1: long (5-byte) command.
- An inter-byte timeout discards partial long commands so the link resynchronises after host glitches.

Parameters:
- TIMEOUT_CYCLES, 100000: clock cycles allowed between consecutive bytes of a long command before it is discarded (1 ms at 100 MHz). Legal range 2..2^24.

Ports:
- clock  input  1  system clock, all state updates on the rising edge
- ext_reset_n  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte from the UART receiver
- rx_valid  input  1  one-cycle strobe; `rx_data` is valid in that cycle
- opcode  output  8  opcode of the last completed command
- command  output  32  payload of the last completed command, little-endian
- cmd_recv_rx  output  1  one-cycle pulse: `opcode`/`command` hold a newly completed command
- cmd_long  output  1  high if the last completed command was a long command
- timeout_err  output  1  one-cycle pulse when a partial long command is discarded

Behaviour:
- Reset (`ext_reset_n` low, asynchronous):
  - Outputs: `opcode`=0x00, `command`=0, `cmd_recv_rx`=0, `cmd_long`=0, `timeout_err`=0.
  - Internal state: FSM=IDLE, byte count=0, timeout counter=0, shift register=0.
- Reset asserted mid-command discards the partial command; no strobe is issued.
- States: IDLE, COLLECT.
- IDLE:
  - On `rx_valid` with `rx_data[7]`=0 (short command):
    - Next cycle: `opcode`=`rx_data`, `command`=0, `cmd_long`=0, `cmd_recv_rx`=1.
    - Stay in IDLE.
  - On `rx_valid` with `rx_data[7]`=1 (long command):
    - Latch the opcode into a pending register; the `opcode` output is unchanged.
    - Clear the byte count and timeout counter.
    - Go to COLLECT.
- COLLECT:
  - Each `rx_valid` shifts `rx_data` in: 1st data byte -> `command[7:0]`, 2nd -> `[15:8]`, 3rd -> `[23:16]`, 4th -> `[31:24]`.
  - Each `rx_valid` clears the timeout counter and increments the byte count.
  - On the 4th data byte:
    - Next cycle: `opcode`=pending opcode, `command`=assembled word, `cmd_long`=1, `cmd_recv_rx`=1.
    - FSM returns to IDLE.
  - Without `rx_valid`, the timeout counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no `rx_valid` that cycle:
    - Next cycle: `timeout_err`=1.
    - FSM goes to IDLE; the pending opcode, byte count and shift register are cleared.
    - `opcode`/`command`/`cmd_long` are unchanged.
  - Simultaneous `rx_valid` and timeout-terminal cycle: the byte wins, is accepted, and the counter clears.
- Latency: `cmd_recv_rx` asserts exactly one cycle after the `rx_valid` that completes a command.
- Output hold:
  - `opcode`, `command` and `cmd_long` are registered and hold until the next completed command.
  - The controller samples `opcode` in the cycle after the strobe, so these outputs must not change during a following partial long command.
- Throughput: `rx_valid` may assert on consecutive cycles.
  - A short command arriving the cycle after a long command completes produces a second strobe the following cycle.
- `cmd_recv_rx` and `timeout_err` are never high in the same cycle.
- The SUMP reset sequence (five 0x00 bytes) decodes as five short 0x00 commands, one strobe each.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES)`. It saturates; no wrap-around in IDLE (held at 0).

Test Plan:
- Short command: release reset; single `rx_valid` with 0x02 -> next cycle `cmd_recv_rx`=1 for one cycle, `opcode`=0x02, `command`=0x00000000, `cmd_long`=0.
- Long command: bytes 0x80,0x10,0x32,0x54,0x76 spaced 3 cycles apart -> one strobe, one cycle after the 0x76 byte, with `opcode`=0x80, `command`=0x76543210, `cmd_long`=1. No strobe on earlier bytes.
- Back-to-back bytes:
  - Stimulus: 0xC0,0x01,0x00,0x00,0x00,0x04 on six consecutive cycles.
  - Strobe 1: `opcode`=0xC0, `command`=0x00000001.
  - Strobe 2, next cycle: `opcode`=0x04, `command`=0, `cmd_long`=0.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: send 0x81,0xAA, then idle 20 cycles.
  - Required: `timeout_err` pulses once, 16 cycles after 0xAA; `opcode` keeps its prior value.
  - Then send 0x02: normal short strobe.
  - Edge case: a byte arriving exactly on the terminal cycle is accepted, with no `timeout_err`.
- Reset mid-command:
  - Stimulus: send 0x82,0x11,0x22, then pulse `ext_reset_n` low asynchronously between edges.
  - Required: all outputs 0 immediately.
  - Follow-up: sending 0x33,0x44 yields two short-command strobes (0x33, 0x44), not a long completion.
- SUMP reset: five 0x00 bytes -> five strobes with `opcode`=0x00, `command`=0; `timeout_err` never asserts.
